// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FPU add/sub front end.
// Optional specials are enabled with FPU_ADDSUB_SPECIALS_EN; the types here are always present.
package fpu_pkg;

  localparam int EXP_W_DEF = 11;
  localparam int MAN_W_DEF = 52;

  // Unpacked view of an operand in the default (binary64) format.
  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF:0]   sig;
  } fp_unpacked_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic invalid;
  } fp_special_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fpu_addsub_align_if.sv
// Operand/result bundle for fpu_addsub_align.
// With FPU_ADDSUB_SPECIALS_EN defined the bundle also carries nan/inf/invalid.
interface fpu_addsub_align_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) ();
  localparam int OP_W = 1 + EXP_W + MAN_W;

  // Valid/ready: a transfer happens on a rising clk edge where valid && ready.
  // The source holds its payload stable while valid && !ready; in_ready may
  // depend combinationally on out_ready.
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opa;
  logic [OP_W-1:0]   opb;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [MAN_W+3:0]  sum;
  logic [EXP_W:0]    exponent;
  logic              sticky;
  logic              zero;
`ifdef FPU_ADDSUB_SPECIALS_EN
  logic              nan;
  logic              inf;
  logic              invalid;

  modport master (
    output in_valid, opa, opb, sub, out_ready,
    input  in_ready, out_valid, sign, sum, exponent, sticky, zero, nan, inf, invalid
  );
  modport slave (
    input  in_valid, opa, opb, sub, out_ready,
    output in_ready, out_valid, sign, sum, exponent, sticky, zero, nan, inf, invalid
  );
`else
  modport master (
    output in_valid, opa, opb, sub, out_ready,
    input  in_ready, out_valid, sign, sum, exponent, sticky, zero
  );
  modport slave (
    input  in_valid, opa, opb, sub, out_ready,
    output in_ready, out_valid, sign, sum, exponent, sticky, zero
  );
`endif
endinterface

// File: rtl/fpu_align_shift.sv
// Right shifter that reports whether any set bit was shifted out (sticky).
// Shift amounts of W or more clear the data and fold every input bit into sticky.
module fpu_align_shift #(
  parameter int W    = 56,
  parameter int SH_W = 11
) (
  input  logic [W-1:0]    i_data,
  input  logic [SH_W-1:0] i_shamt,
  output logic [W-1:0]    o_data,
  output logic            o_sticky
);
  localparam int unsigned LIM = W;

  logic [W-1:0] w_lost_mask;

  always_comb begin
    w_lost_mask = '0;
    o_data      = '0;
    o_sticky    = 1'b0;
    if (32'(i_shamt) >= LIM) begin
      o_sticky = |i_data;
    end else begin
      o_data      = i_data >> i_shamt;
      w_lost_mask = ~({W{1'b1}} << i_shamt);
      o_sticky    = |(i_data & w_lost_mask);
    end
  end

endmodule

// File: rtl/fpu_addsub_align.sv
// Four-stage IEEE-754 add/sub front end: unpack/swap, align with sticky, magnitude add/sub, carry fix-up.
// NaN/Inf handling is compiled in with FPU_ADDSUB_SPECIALS_EN; otherwise all-ones exponents are ordinary numbers.
module fpu_addsub_align
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  fpu_addsub_align_if.slave bus
);
  localparam int OP_W  = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int SUM_W = MAN_W + 4;

  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXPW_ONE = {{EXP_W{1'b0}}, 1'b1};

  logic             w_adv;

  logic             w_a_sign, w_b_sign, w_b_sign_eff, w_eff_sub, w_a_ge, w_s1_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp, w_a_eexp, w_b_eexp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic [SIG_W-1:0] w_a_sig, w_b_sig;

  logic             r_s1_valid, r_s1_eff_sub, r_s1_sign;
  logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
  logic [SIG_W-1:0] r_s1_large, r_s1_small;

  logic [SUM_W-1:0] w_small_ext, w_small_al;
  logic             w_al_sticky;

  logic             r_s2_valid, r_s2_eff_sub, r_s2_sign, r_s2_sticky;
  logic [EXP_W-1:0] r_s2_exp;
  logic [SUM_W-1:0] r_s2_large, r_s2_small;

  logic [SUM_W-1:0] w_s3_sum;
  logic             r_s3_valid, r_s3_sign, r_s3_sticky;
  logic [EXP_W-1:0] r_s3_exp;
  logic [SUM_W-1:0] r_s3_sum;

  logic [SUM_W-1:0] w_fix_sum;
  logic [EXP_W:0]   w_fix_exp;
  logic             w_fix_sticky, w_fix_zero, w_fix_sign;

  logic             r_out_valid, r_out_sign, r_out_sticky, r_out_zero;
  logic [SUM_W-1:0] r_out_sum;
  logic [EXP_W:0]   r_out_exp;

  // Whole pipeline advances together; only a stalled output blocks it.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  assign w_a_sign = bus.opa[OP_W-1];
  assign w_b_sign = bus.opb[OP_W-1];
  assign w_a_exp  = bus.opa[OP_W-2 -: EXP_W];
  assign w_b_exp  = bus.opb[OP_W-2 -: EXP_W];
  assign w_a_man  = bus.opa[MAN_W-1:0];
  assign w_b_man  = bus.opb[MAN_W-1:0];

  assign w_b_sign_eff = w_b_sign ^ bus.sub;
  assign w_eff_sub    = w_a_sign ^ w_b_sign ^ bus.sub;
  assign w_a_ge       = bus.opa[OP_W-2:0] >= bus.opb[OP_W-2:0];

  // Denormals use exponent 1 with hidden bit 0, so no separate adjustment is needed.
  assign w_a_eexp = (w_a_exp == '0) ? EXP_ONE : w_a_exp;
  assign w_b_eexp = (w_b_exp == '0) ? EXP_ONE : w_b_exp;
  assign w_a_sig  = {(w_a_exp != '0), w_a_man};
  assign w_b_sig  = {(w_b_exp != '0), w_b_man};

`ifdef FPU_ADDSUB_SPECIALS_EN
  logic        w_a_max, w_b_max, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_a_snan, w_b_snan, w_inf_inf, w_any_nan;
  fp_special_t w_s1_spec, r_s1_spec, r_s2_spec, r_s3_spec, r_out_spec;

  assign w_a_max   = &w_a_exp;
  assign w_b_max   = &w_b_exp;
  assign w_a_inf   = w_a_max && (w_a_man == '0);
  assign w_b_inf   = w_b_max && (w_b_man == '0);
  assign w_a_nan   = w_a_max && (w_a_man != '0);
  assign w_b_nan   = w_b_max && (w_b_man != '0);
  assign w_a_snan  = w_a_nan && !w_a_man[MAN_W-1];
  assign w_b_snan  = w_b_nan && !w_b_man[MAN_W-1];
  assign w_inf_inf = w_a_inf && w_b_inf && w_eff_sub;
  assign w_any_nan = w_a_nan || w_b_nan || w_inf_inf;
  assign w_s1_spec = '{nan:     w_any_nan,
                       inf:     !w_any_nan && (w_a_inf || w_b_inf),
                       invalid: w_a_snan || w_b_snan || w_inf_inf};
`endif

  always_comb begin
    w_s1_sign = w_a_ge ? w_a_sign : w_b_sign_eff;
`ifdef FPU_ADDSUB_SPECIALS_EN
    if (w_s1_spec.inf) w_s1_sign = w_a_inf ? w_a_sign : w_b_sign_eff;
`endif
  end

  assign w_small_ext = {1'b0, r_s1_small, 2'b00};

  fpu_align_shift #(
    .W    (SUM_W),
    .SH_W (EXP_W)
  ) u_align (
    .i_data   (w_small_ext),
    .i_shamt  (r_s1_diff),
    .o_data   (w_small_al),
    .o_sticky (w_al_sticky)
  );

  // A set sticky means the true small operand is slightly larger, so subtract borrows one LSB.
  assign w_s3_sum = r_s2_eff_sub
                  ? (r_s2_large - r_s2_small - {{(SUM_W-1){1'b0}}, r_s2_sticky})
                  : (r_s2_large + r_s2_small);

  always_comb begin
    w_fix_sum    = r_s3_sum;
    w_fix_sticky = r_s3_sticky;
    w_fix_exp    = {1'b0, r_s3_exp};
    w_fix_sign   = r_s3_sign;
    if (r_s3_sum[SUM_W-1]) begin
      w_fix_sum    = r_s3_sum >> 1;
      w_fix_sticky = r_s3_sticky | r_s3_sum[0];
      w_fix_exp    = {1'b0, r_s3_exp} + EXPW_ONE;
    end
    w_fix_zero = (r_s3_sum == '0) && !r_s3_sticky;
    if (w_fix_zero) begin
      w_fix_sign = 1'b0;
      w_fix_exp  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_diff    <= '0;
      r_s1_large   <= '0;
      r_s1_small   <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_eff_sub <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_sticky  <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_large   <= '0;
      r_s2_small   <= '0;
      r_s3_valid   <= 1'b0;
      r_s3_sign    <= 1'b0;
      r_s3_sticky  <= 1'b0;
      r_s3_exp     <= '0;
      r_s3_sum     <= '0;
      r_out_valid  <= 1'b0;
      r_out_sign   <= 1'b0;
      r_out_sticky <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_sum    <= '0;
      r_out_exp    <= '0;
    end else if (w_adv) begin
      r_s1_valid   <= bus.in_valid;
      r_s1_eff_sub <= w_eff_sub;
      r_s1_sign    <= w_s1_sign;
      r_s1_exp     <= w_a_ge ? w_a_eexp : w_b_eexp;
      r_s1_diff    <= w_a_ge ? (w_a_eexp - w_b_eexp) : (w_b_eexp - w_a_eexp);
      r_s1_large   <= w_a_ge ? w_a_sig : w_b_sig;
      r_s1_small   <= w_a_ge ? w_b_sig : w_a_sig;

      r_s2_valid   <= r_s1_valid;
      r_s2_eff_sub <= r_s1_eff_sub;
      r_s2_sign    <= r_s1_sign;
      r_s2_sticky  <= w_al_sticky;
      r_s2_exp     <= r_s1_exp;
      r_s2_large   <= {1'b0, r_s1_large, 2'b00};
      r_s2_small   <= w_small_al;

      r_s3_valid   <= r_s2_valid;
      r_s3_sign    <= r_s2_sign;
      r_s3_sticky  <= r_s2_sticky;
      r_s3_exp     <= r_s2_exp;
      r_s3_sum     <= w_s3_sum;

      r_out_valid  <= r_s3_valid;
      r_out_sign   <= w_fix_sign;
      r_out_sticky <= w_fix_sticky;
      r_out_zero   <= w_fix_zero;
      r_out_sum    <= w_fix_sum;
      r_out_exp    <= w_fix_exp;
    end
  end

`ifdef FPU_ADDSUB_SPECIALS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_spec  <= '0;
      r_s2_spec  <= '0;
      r_s3_spec  <= '0;
      r_out_spec <= '0;
    end else if (w_adv) begin
      r_s1_spec  <= w_s1_spec;
      r_s2_spec  <= r_s1_spec;
      r_s3_spec  <= r_s2_spec;
      r_out_spec <= r_s3_spec;
    end
  end

  assign bus.nan     = r_out_spec.nan;
  assign bus.inf     = r_out_spec.inf;
  assign bus.invalid = r_out_spec.invalid;
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.sign      = r_out_sign;
  assign bus.sum       = r_out_sum;
  assign bus.exponent  = r_out_exp;
  assign bus.sticky    = r_out_sticky;
  assign bus.zero      = r_out_zero;

endmodule

// File: tb/tb_fpu_addsub_align.sv
// Directed bench for fpu_addsub_align (binary64); the specials tests build with FPU_ADDSUB_SPECIALS_EN.
module tb_fpu_addsub_align;
  import fpu_pkg::*;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int SUM_W = MAN_W + 4;
  localparam int RES_W = 1 + SUM_W + (EXP_W + 1) + 2;

  localparam logic [63:0] ONE     = 64'h3FF0000000000000;
  localparam logic [63:0] M_ONE   = 64'hBFF0000000000000;
  localparam logic [63:0] TWO     = 64'h4000000000000000;
  localparam logic [63:0] TINY    = 64'h3C30000000000000;
  localparam logic [63:0] DEN_MAX = 64'h000FFFFFFFFFFFFF;
  localparam logic [63:0] DEN_MIN = 64'h0000000000000001;
  localparam logic [63:0] P_INF   = 64'h7FF0000000000000;
  localparam logic [63:0] N_INF   = 64'hFFF0000000000000;
  localparam logic [SUM_W-1:0] HID = 56'h40000000000000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [RES_W-1:0] exp_q[$];

  fpu_addsub_align_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fpu_addsub_align #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RES_W-1:0] mk(input logic s, input logic [SUM_W-1:0] m,
                                          input logic [EXP_W:0] e, input logic st, input logic z);
    return {s, m, e, st, z};
  endfunction

  function automatic logic [RES_W-1:0] res_now();
    return {bus.sign, bus.sum, bus.exponent, bus.sticky, bus.zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, then wait (bounded) for its result with out_ready high.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output int lat, output bit got);
    bus.opa       = a;
    bus.opb       = b;
    bus.sub       = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.opa = ONE;
    bus.opb = ONE;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.sign !== 1'b0) begin errors++; $display("FAIL reset_sign: got %b want 0", bus.sign); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
    checks++; if (bus.exponent !== '0) begin errors++; $display("FAIL reset_exponent: got %h want 0", bus.exponent); end
    checks++; if (bus.sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", bus.sticky); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_add_basic();
    int lat;
    bit got;
    logic [EXP_W:0] e_two;
    e_two = 12'(fp_bias(EXP_W) + 1);
    run_op(ONE, ONE, 1'b0, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL add_valid: out_valid never rose"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++; if (bus.sum !== HID) begin errors++; $display("FAIL add_sum: got %h want %h", bus.sum, HID); end
    checks++; if (bus.exponent !== e_two) begin errors++; $display("FAIL add_exponent: got %h want %h", bus.exponent, e_two); end
    checks++; if (bus.sticky !== 1'b0) begin errors++; $display("FAIL add_sticky: got %b want 0", bus.sticky); end
    checks++; if (bus.sign !== 1'b0) begin errors++; $display("FAIL add_sign: got %b want 0", bus.sign); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", bus.zero); end
  endtask

  task automatic test_cancel();
    logic [63:0]      va[2];
    logic [63:0]      vb[2];
    logic             vs[2];
    logic [RES_W-1:0] want;
    int lat;
    bit got;
    va = '{ONE, ONE};
    vb = '{ONE, M_ONE};
    vs = '{1'b1, 1'b0};
    want = mk(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], vs[i], lat, got);
      checks++; if (!got) begin errors++; $display("FAIL cancel_valid[%0d]: out_valid never rose", i); end
      checks++; if (res_now() !== want) begin errors++; $display("FAIL cancel[%0d]: got %h want %h", i, res_now(), want); end
    end
  endtask

  task automatic test_sticky_far();
    int lat;
    bit got;
    logic [RES_W-1:0] want;
    run_op(ONE, TINY, 1'b0, lat, got);
    want = mk(1'b0, HID, 12'h3FF, 1'b1, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL far_add: got %h want %h", res_now(), want); end
    run_op(ONE, TINY, 1'b1, lat, got);
    want = mk(1'b0, 56'h3FFFFFFFFFFFFF, 12'h3FF, 1'b1, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL far_sub_borrow: got %h want %h", res_now(), want); end
  endtask

  task automatic test_partial_shift();
    int lat;
    bit got;
    logic [RES_W-1:0] want;
    run_op(ONE, 64'h3FC0000000000001, 1'b0, lat, got);
    want = mk(1'b0, 56'h48000000000000, 12'h3FF, 1'b1, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL shift3_sticky: got %h want %h", res_now(), want); end
    run_op(ONE, 64'h3FD0000000000001, 1'b0, lat, got);
    want = mk(1'b0, 56'h50000000000001, 12'h3FF, 1'b0, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL shift2_round: got %h want %h", res_now(), want); end
  endtask

  task automatic test_denorm();
    int lat;
    bit got;
    logic [RES_W-1:0] want;
    run_op(DEN_MAX, DEN_MIN, 1'b0, lat, got);
    want = mk(1'b0, HID, 12'h001, 1'b0, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL denorm_to_normal: got %h want %h", res_now(), want); end
  endtask

  task automatic test_signs();
    int lat;
    bit got;
    logic [RES_W-1:0] want;
    run_op(ONE, TWO, 1'b1, lat, got);
    want = mk(1'b1, 56'h20000000000000, 12'h400, 1'b0, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL sign_one_minus_two: got %h want %h", res_now(), want); end
    run_op(M_ONE, M_ONE, 1'b0, lat, got);
    want = mk(1'b1, HID, 12'h400, 1'b0, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL sign_neg_add: got %h want %h", res_now(), want); end
    run_op(M_ONE, ONE, 1'b1, lat, got);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL sign_tie_opa: got %h want %h", res_now(), want); end
  endtask

  task automatic test_back_to_back();
    logic [63:0]      va[8];
    logic [63:0]      vb[8];
    logic             vs[8];
    logic [RES_W-1:0] ve[8];
    logic [RES_W-1:0] want;
    int idx;
    int got;
    bit acc;
    va = '{ONE, ONE, ONE, DEN_MAX, ONE, ONE, ONE, ONE};
    vb = '{ONE, ONE, TINY, DEN_MIN, TINY, TWO, 64'h3FC0000000000001, 64'h3FD0000000000001};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ve[0] = mk(1'b0, HID, 12'h400, 1'b0, 1'b0);
    ve[1] = mk(1'b0, '0, '0, 1'b0, 1'b1);
    ve[2] = mk(1'b0, HID, 12'h3FF, 1'b1, 1'b0);
    ve[3] = mk(1'b0, HID, 12'h001, 1'b0, 1'b0);
    ve[4] = mk(1'b0, 56'h3FFFFFFFFFFFFF, 12'h3FF, 1'b1, 1'b0);
    ve[5] = mk(1'b1, 56'h20000000000000, 12'h400, 1'b0, 1'b0);
    ve[6] = mk(1'b0, 56'h48000000000000, 12'h3FF, 1'b1, 1'b0);
    ve[7] = mk(1'b0, 56'h50000000000001, 12'h3FF, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    exp_q.delete();
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      bus.in_valid  = (idx < 8);
      if (idx < 8) begin
        bus.opa = va[idx];
        bus.opb = vb[idx];
        bus.sub = vs[idx];
      end
      #1;
      checks++;
      if (bus.in_ready !== !(c >= 5 && c <= 7)) begin
        errors++; $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, bus.in_ready, !(c >= 5 && c <= 7));
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_output c=%0d: got %h want none", c, res_now());
        end else begin
          want = exp_q.pop_front();
          if (res_now() !== want) begin errors++; $display("FAIL b2b_result %0d: got %h want %h", got, res_now(), want); end
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_q.push_back(ve[idx]);
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_duplicate k=%0d: got out_valid %b want 0", k, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    bus.opa = ONE;
    bus.opb = ONE;
    bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_discard: got %0d outputs want 0", seen); end
  endtask

`ifdef FPU_ADDSUB_SPECIALS_EN
  task automatic test_specials();
    int lat;
    bit got;
    run_op(P_INF, N_INF, 1'b0, lat, got);
    checks++; if (!got || bus.nan !== 1'b1) begin errors++; $display("FAIL inf_minus_inf_nan: got %b want 1", bus.nan); end
    checks++; if (bus.invalid !== 1'b1) begin errors++; $display("FAIL inf_minus_inf_invalid: got %b want 1", bus.invalid); end
    run_op(N_INF, ONE, 1'b0, lat, got);
    checks++; if (!got || bus.inf !== 1'b1) begin errors++; $display("FAIL neg_inf_inf: got %b want 1", bus.inf); end
    checks++; if (bus.sign !== 1'b1) begin errors++; $display("FAIL neg_inf_sign: got %b want 1", bus.sign); end
    checks++; if (bus.nan !== 1'b0) begin errors++; $display("FAIL neg_inf_nan: got %b want 0", bus.nan); end
    run_op(64'h7FF0000000000001, ONE, 1'b0, lat, got);
    checks++; if (!got || {bus.nan, bus.invalid} !== 2'b11) begin errors++; $display("FAIL snan: got %b want 11", {bus.nan, bus.invalid}); end
    run_op(64'h7FF8000000000000, ONE, 1'b0, lat, got);
    checks++; if (!got || {bus.nan, bus.invalid} !== 2'b10) begin errors++; $display("FAIL qnan: got %b want 10", {bus.nan, bus.invalid}); end
  endtask
`else
  task automatic test_exp_overflow();
    int lat;
    bit got;
    logic [RES_W-1:0] want;
    run_op(P_INF, P_INF, 1'b0, lat, got);
    want = mk(1'b0, HID, 12'h800, 1'b0, 1'b0);
    checks++; if (!got || res_now() !== want) begin errors++; $display("FAIL exp_overflow: got %h want %h", res_now(), want); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.opa = '0;
    bus.opb = '0;
    bus.sub = 1'b0;
    test_reset();
    test_add_basic();
    test_cancel();
    test_sticky_far();
    test_partial_shift();
    test_denorm();
    test_signs();
    test_back_to_back();
    test_mid_reset();
`ifdef FPU_ADDSUB_SPECIALS_EN
    test_specials();
`else
    test_exp_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
